// File: rtl/div_pkg.sv
// Shared types and sizing helpers for the EX-stage iterative divider.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_t;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_ITERS = DIV_WIDTH;
    localparam int DIV_CNT_W = $clog2(DIV_WIDTH) + 1;

    // Counter must hold the value WIDTH itself, hence the extra bit.
    function automatic int cntWidth(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/div_iter.sv
// One radix-2 restoring shift-subtract step on unsigned magnitudes.
module div_iter #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   remIn,
    input  logic [WIDTH-1:0] quoIn,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   remOut,
    output logic [WIDTH-1:0] quoOut
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;
    logic           geq;

    assign shifted = {remIn[WIDTH-1:0], quoIn[WIDTH-1]};
    assign diff    = shifted - {1'b0, divisor};
    // The partial remainder top bit is always clear between steps; folding it
    // in keeps the compare exact should a wider value ever arrive.
    assign geq     = remIn[WIDTH] | (shifted >= {1'b0, divisor});

    always_comb begin
        remOut = shifted;
        quoOut = {quoIn[WIDTH-2:0], 1'b0};
        if (geq) begin
            remOut = diff;
            quoOut = {quoIn[WIDTH-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/div_unit.sv
// Iterative DIV/DIVU unit for the EX stage: FSM, operand registers, sign fix-up
// and the stall/valid handshake towards the hazard unit and HI/LO.
module div_unit
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             startE,
    input  logic             signedE,
    input  logic [WIDTH-1:0] srcaE,
    input  logic [WIDTH-1:0] srcbE,
    input  logic             flushE,
    input  logic             holdE,
    output logic             div_stallE,
    output logic             div_validE,
    output logic [WIDTH-1:0] quotientE,
    output logic [WIDTH-1:0] remainderE
);

    localparam int               CNT_W     = cntWidth(WIDTH);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    div_state_t       stateReg, stateNext;
    logic [CNT_W-1:0] countReg, countNext;
    logic [WIDTH:0]   remReg, remNext;
    logic [WIDTH-1:0] quoReg, quoNext;
    logic [WIDTH-1:0] divisorReg, divisorNext;
    logic             quoNegReg, quoNegNext;
    logic             remNegReg, remNegNext;
    logic             divZeroReg, divZeroNext;

    logic [WIDTH:0]   remStep;
    logic [WIDTH-1:0] quoStep;
    logic             negA, negB;
    logic [WIDTH-1:0] absA, absB;
    logic [WIDTH-1:0] quoFixed, remFixed;
    logic             inIdle, inBusy, inDone;

    assign negA = signedE & srcaE[WIDTH-1];
    assign negB = signedE & srcbE[WIDTH-1];
    assign absA = negA ? (~srcaE + 1'b1) : srcaE;
    assign absB = negB ? (~srcbE + 1'b1) : srcbE;

    div_iter #(
        .WIDTH(WIDTH)
    ) u_iter (
        .remIn  (remReg),
        .quoIn  (quoReg),
        .divisor(divisorReg),
        .remOut (remStep),
        .quoOut (quoStep)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stateReg   <= IDLE;
            countReg   <= '0;
            remReg     <= '0;
            quoReg     <= '0;
            divisorReg <= '0;
            quoNegReg  <= 1'b0;
            remNegReg  <= 1'b0;
            divZeroReg <= 1'b0;
        end else begin
            stateReg   <= stateNext;
            countReg   <= countNext;
            remReg     <= remNext;
            quoReg     <= quoNext;
            divisorReg <= divisorNext;
            quoNegReg  <= quoNegNext;
            remNegReg  <= remNegNext;
            divZeroReg <= divZeroNext;
        end
    end

    always_comb begin
        stateNext   = stateReg;
        countNext   = countReg;
        remNext     = remReg;
        quoNext     = quoReg;
        divisorNext = divisorReg;
        quoNegNext  = quoNegReg;
        remNegNext  = remNegReg;
        divZeroNext = divZeroReg;

        case (stateReg)
            IDLE: begin
                if (startE) begin
                    stateNext   = BUSY;
                    countNext   = '0;
                    remNext     = '0;
                    quoNext     = absA;
                    divisorNext = absB;
                    quoNegNext  = negA ^ negB;
                    remNegNext  = negA;
                    divZeroNext = ~|srcbE;
                end
            end
            BUSY: begin
                remNext   = remStep;
                quoNext   = quoStep;
                countNext = countReg + 1'b1;
                if (countReg == LAST_STEP) begin
                    stateNext = DONE;
                end
            end
            DONE: begin
                // startE is deliberately ignored here so the same instruction
                // cannot retrigger while it sits in EX.
                if (!holdE) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase

        if (flushE) begin
            stateNext = IDLE;
        end
    end

    // Divide-by-zero needs only the quotient override: the remainder magnitude
    // equals |a| and the remainder sign fix-up restores srcaE exactly.
    assign quoFixed = divZeroReg ? {WIDTH{1'b1}} :
                      (quoNegReg ? (~quoReg + 1'b1) : quoReg);
    assign remFixed = remNegReg ? (~remReg[WIDTH-1:0] + 1'b1) : remReg[WIDTH-1:0];

    assign inIdle = (stateReg == IDLE);
    assign inBusy = (stateReg == BUSY);
    assign inDone = (stateReg == DONE);

    assign div_stallE = resetn & ~flushE & ((inIdle & startE) | inBusy);
    assign div_validE = inDone & ~flushE;
    assign quotientE  = inDone ? quoFixed : '0;
    assign remainderE = inDone ? remFixed : '0;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: expected results are queued at issue and
// compared when div_validE rises, alongside stall-length and handshake checks.
module tb_div_unit;

    typedef struct packed {
        logic [31:0] q;
        logic [31:0] r;
    } exp_t;

    logic        clk = 1'b0;
    logic        resetn;
    logic        startE, signedE, flushE, holdE;
    logic [31:0] srcaE, srcbE;
    logic        div_stallE, div_validE;
    logic [31:0] quotientE, remainderE;

    int   checks   = 0;
    int   failures = 0;
    exp_t sbQ[$];

    always #5 clk = ~clk;

    div_unit #(.WIDTH(32)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .startE    (startE),
        .signedE   (signedE),
        .srcaE     (srcaE),
        .srcbE     (srcbE),
        .flushE    (flushE),
        .holdE     (holdE),
        .div_stallE(div_stallE),
        .div_validE(div_validE),
        .quotientE (quotientE),
        .remainderE(remainderE)
    );

    task automatic checkResult(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            failures++;
            $display("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
        end
    endtask

    function automatic exp_t modelDiv(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        logic signed [31:0] sa, sb;
        sa = a;
        sb = b;
        if (b == 32'd0) begin
            e.q = 32'hFFFF_FFFF;
            e.r = a;
        end else if (!sgn) begin
            e.q = a / b;
            e.r = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            e.q = 32'h8000_0000;
            e.r = 32'd0;
        end else begin
            e.q = sa / sb;
            e.r = sa % sb;
        end
        return e;
    endfunction

    // Issues one divide at the next falling edge and follows it to completion.
    // With holdCycles==0 startE is left high so a following call issues back-to-back.
    task automatic runDiv(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          input int holdCycles);
        exp_t e;
        int   stalls;
        bit   seen;
        @(negedge clk);
        startE  = 1'b1;
        signedE = sgn;
        srcaE   = a;
        srcbE   = b;
        holdE   = (holdCycles > 0);
        sbQ.push_back(modelDiv(sgn, a, b));
        stalls = 0;
        seen   = 1'b0;
        for (int c = 0; c < 100 && !seen; c++) begin
            #1;
            if (div_validE) begin
                seen = 1'b1;
            end else begin
                if (div_stallE) stalls++;
                @(negedge clk);
            end
        end
        e = sbQ.pop_front();
        checkResult("valid_seen", 32'(seen), 32'd1);
        checkResult("stall_cycles", stalls, 32'd33);
        checkResult("quotient", quotientE, e.q);
        checkResult("remainder", remainderE, e.r);
        checkResult("stall_in_done", 32'(div_stallE), 32'd0);
        $display("div sgn=%0d a=0x%08h b=0x%08h q=0x%08h r=0x%08h stalls=%0d",
                 sgn, a, b, quotientE, remainderE, stalls);
        for (int k = 0; k < holdCycles; k++) begin
            @(negedge clk);
            if (k == holdCycles - 1) holdE = 1'b0;
            #1;
            checkResult("hold_valid", 32'(div_validE), 32'd1);
            checkResult("hold_stall", 32'(div_stallE), 32'd0);
            checkResult("hold_q", quotientE, e.q);
            checkResult("hold_r", remainderE, e.r);
        end
    endtask

    task automatic idleCheck(input string tag);
        @(negedge clk);
        startE = 1'b0;
        #1;
        checkResult({tag, "_stall"}, 32'(div_stallE), 32'd0);
        checkResult({tag, "_valid"}, 32'(div_validE), 32'd0);
    endtask

    initial begin
        resetn  = 1'b0;
        startE  = 1'b0;
        signedE = 1'b0;
        flushE  = 1'b0;
        holdE   = 1'b0;
        srcaE   = '0;
        srcbE   = '0;
        #12;
        checkResult("rst_stall", 32'(div_stallE), 32'd0);
        checkResult("rst_valid", 32'(div_validE), 32'd0);
        checkResult("rst_q", quotientE, 32'd0);
        checkResult("rst_r", remainderE, 32'd0);
        @(negedge clk);
        resetn = 1'b1;

        runDiv(1'b0, 32'd100, 32'd7, 0);
        runDiv(1'b1, 32'hFFFF_FFF9, 32'd2, 0);
        runDiv(1'b1, 32'd7, 32'hFFFF_FFFE, 0);
        runDiv(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        runDiv(1'b0, 32'd5, 32'd0, 0);
        runDiv(1'b1, 32'hFFFF_FFF7, 32'd0, 0);
        runDiv(1'b0, 32'hFFFF_FFFF, 32'd1, 0);
        for (int i = 0; i < 4; i++) begin
            runDiv(i[0], $urandom, $urandom_range(1, 32'h0001_FFFF), 0);
        end
        idleCheck("idle_a");

        // Flush in the middle of BUSY, then a fresh divide one cycle later.
        @(negedge clk);
        startE  = 1'b1;
        signedE = 1'b0;
        srcaE   = 32'd100;
        srcbE   = 32'd7;
        repeat (10) @(negedge clk);
        flushE = 1'b1;
        #1;
        checkResult("flush_stall", 32'(div_stallE), 32'd0);
        checkResult("flush_valid", 32'(div_validE), 32'd0);
        @(negedge clk);
        flushE = 1'b0;
        startE = 1'b0;
        #1;
        checkResult("post_flush_stall", 32'(div_stallE), 32'd0);
        runDiv(1'b0, 32'd9, 32'd3, 0);
        idleCheck("idle_b");

        // Hold in DONE with startE still asserted.
        runDiv(1'b0, 32'd1000, 32'd33, 4);
        idleCheck("after_hold");

        // Asynchronous reset in the middle of BUSY.
        @(negedge clk);
        startE  = 1'b1;
        signedE = 1'b0;
        srcaE   = 32'd200;
        srcbE   = 32'd9;
        repeat (20) @(negedge clk);
        #2;
        resetn = 1'b0;
        #1;
        checkResult("mid_rst_stall", 32'(div_stallE), 32'd0);
        checkResult("mid_rst_valid", 32'(div_validE), 32'd0);
        checkResult("mid_rst_q", quotientE, 32'd0);
        checkResult("mid_rst_r", remainderE, 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        startE = 1'b0;
        #1;
        checkResult("post_rst_stall", 32'(div_stallE), 32'd0);
        runDiv(1'b0, 32'd200, 32'd9, 0);
        idleCheck("idle_c");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/div_unit.md
# div_unit

Iterative radix-2 divider with its sequencing controller for the EX stage of the 5-stage MIPS pipeline. It accepts a DIV/DIVU operation from EX and runs a fixed-latency shift-subtract sequence. While the operation is in flight it drives the `div_stallE` signal consumed by the hazard unit. It then presents quotient (to LO) and remainder (to HI) for exactly the cycle in which the instruction leaves EX.

## Interface
Parameters:
- `WIDTH`, default 32: operand/result width; iteration count equals `WIDTH`.

Ports:
- `clk`, in, 1: single clock; all state on rising edge.
- `resetn`, in, 1: asynchronous, active-low reset.
- `startE`, in, 1: valid DIV/DIVU in EX (already qualified by EX-valid).
- `signedE`, in, 1: 1 = DIV (two's complement), 0 = DIVU.
- `srcaE`, in, `WIDTH`: dividend (rs).
- `srcbE`, in, `WIDTH`: divisor (rt).
- `flushE`, in, 1: annul the EX-stage instruction (exception/flush).
- `holdE`, in, 1: EX cannot advance for a reason other than this unit.
- `div_stallE`, out, 1: stall request to the hazard unit.
- `div_validE`, out, 1: result valid; HI/LO write enable this cycle.
- `quotientE`, out, `WIDTH`: quotient, written to LO.
- `remainderE`, out, `WIDTH`: remainder, written to HI.

## Operation
- FSM states:
  - `IDLE`: no operation in flight.
  - `BUSY`: shift-subtract iterations in progress.
  - `DONE`: result presented.
- IDLE → BUSY on `startE & ~flushE`:
  - Latch `|srcaE|` and `|srcbE|`; absolute value applies only when `signedE`.
  - Latch sign flags: quotient negative = `a[MSB]^b[MSB]`; remainder negative = `a[MSB]`.
  - Zero the partial remainder (`WIDTH+1` bits) and the counter.
- BUSY step, once per cycle:
  - `{rem,quo} <<= 1`.
  - If `rem >= divisor`: `rem -= divisor`, set `quo[0]=1`.
  - Increment counter.
  - Go to DONE after step `WIDTH`.
- DONE:
  - Outputs carry the sign-corrected results.
  - Stays in DONE while `holdE`; goes to IDLE when `~holdE`.
  - `startE` is ignored in DONE, so the same instruction never restarts.
- `flushE` in any state: next state IDLE and the partial result is discarded. `div_validE` is 0 in the flush cycle.
- Divide by zero, signed or unsigned: `quotientE = {WIDTH{1'b1}}`, `remainderE = srcaE`. No fault is raised.
- Signed overflow, `0x80000000 / 0xFFFFFFFF`: `quotientE = 0x80000000`, `remainderE = 0`. Unsigned magnitudes make this fall out naturally.
- Sign correction is two's-complement negation of the magnitude, applied when the latched flag is set.

## Timing
- Reset (async, `resetn=0`):
  - State IDLE, counter 0, operand/result registers 0.
  - `div_stallE=0`, `div_validE=0`, `quotientE=0`, `remainderE=0`.
- Stall equations (combinational):
  - `div_stallE = ~flushE & ((IDLE & startE) | BUSY)`.
  - `div_validE = DONE & ~flushE`.
- Latency: with `startE` first seen at cycle 0 in IDLE:
  - `div_stallE` is high in cycles 0..`WIDTH` (33 cycles at 32).
  - `div_validE` is high from cycle `WIDTH+1` and stays high while `holdE`.
  - Instruction leaves EX at the end of the first DONE cycle with `holdE=0`.
- Back-to-back divides: the next `startE` is accepted in the cycle after DONE→IDLE, i.e. no dead cycle beyond IDLE.
- `resetn` deasserted mid-BUSY: immediate return to IDLE; outputs 0 asynchronously.
- `flushE` coincident with DONE: no HI/LO write.

## Structure
- Shared package `div_pkg`:
  - State enum `div_state_t {IDLE, BUSY, DONE}`.
  - Iteration-count constant.
  - Counter width `$clog2(WIDTH)+1`.
- Sub-module `div_iter`: one combinational shift-subtract step (partial remainder, quotient, divisor in → next values out).
- Top level holds the FSM, counter, registers and sign correction.

## Test plan
- DIVU `100 / 7`:
  - stall high for 33 cycles, then `div_validE=1`, `quotientE=14`, `remainderE=2`.
- DIV `-7 / 2`: q=`0xFFFFFFFD`, r=`0xFFFFFFFF`.
- DIV `7 / -2`: q=`0xFFFFFFFD`, r=`1`.
- DIV `0x80000000 / 0xFFFFFFFF`: q=`0x80000000`, r=`0`.
- DIVU `5 / 0`: q=`0xFFFFFFFF`, r=`5`, same 33-cycle stall.
- `flushE` pulsed at BUSY cycle 10:
  - stall drops that cycle, no `div_validE`.
  - A new DIVU `9 / 3` starting 1 cycle later returns q=`3`, r=`0`.
- `holdE` high for 4 cycles in DONE with `startE` still high:
  - `div_validE` and results stay stable, no restart, IDLE after `holdE` falls.
- `resetn` low at BUSY cycle 20: all outputs 0 immediately; the next `startE` runs a full 33-cycle operation.
